// File: rtl/regfile_pkg.sv
// Shared defaults and pending-count type for the register file scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_CNT_MAX  = 3;
    localparam int DEF_CNT_W    = $clog2(DEF_CNT_MAX + 1);

    // Pending-write count at the default tracking depth.
    typedef logic [DEF_CNT_W-1:0] pend_cnt_t;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// Per-register saturating up/down counter of in-flight writes.
module pend_counter
    import regfile_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          nonzero
);

    localparam logic [CW-1:0] MAX_V = CW'(CNT_MAX);

    // A simultaneous inc and dec cancel; clear wins over both.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !dec && count != MAX_V)
            count <= count + 1'b1;
        else if (dec && !inc && count != '0)
            count <= count - 1'b1;
    end

    assign full    = (count == MAX_V);
    assign nonzero = (count != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard and decode stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int CNT_MAX  = DEF_CNT_MAX,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]        rd_req,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     iss_full,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     flush
);

    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [AW:0] REG_LIMIT = (AW+1)'(NUM_REGS);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Register 0 and anything past the last register are never stored or tracked.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < REG_LIMIT) && (a != '0);
    endfunction

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CW-1:0]       cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] nz_vec;
    logic                wr_ok;
    logic                iss_hit_full;
    logic                iss_acc;

    assign wr_ok        = wr_en && addr_ok(wr_addr);
    assign iss_hit_full = addr_ok(iss_addr) && full_vec[iss_addr];
    assign iss_acc      = iss_en && addr_ok(iss_addr) && !iss_hit_full;
    assign iss_full     = Reset && iss_hit_full;

    // Data writes proceed even while the scoreboard is being flushed.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign cnt[r]      = '0;
            assign full_vec[r] = 1'b0;
            assign nz_vec[r]   = 1'b0;
        end else begin : g_cnt
            pend_counter #(.CNT_MAX(CNT_MAX), .CW(CW)) u_cnt (
                .Clk     (Clk),
                .Reset   (Reset),
                .inc     (iss_acc && (iss_addr == AW'(r))),
                .dec     (wr_ok && (wr_addr == AW'(r))),
                .clr     (flush),
                .count   (cnt[r]),
                .full    (full_vec[r]),
                .nonzero (nz_vec[r])
            );
        end
    end

    // A forwarded write that retires the last pending entry clears busy early.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          fwd;
        logic          drain;

        assign a     = rd_addr[i*AW +: AW];
        assign ok    = Reset && addr_ok(a);
        assign fwd   = BYPASS && wr_ok && (wr_addr == a);
        assign drain = fwd && (cnt[a] == CW'(1)) && !(iss_acc && (iss_addr == a));

        assign rd_data[i*DATA_W +: DATA_W] = !ok ? '0 : (fwd ? wr_data : regs[a]);
        assign rd_busy[i]                  = ok && nz_vec[a] && !drain;
    end

    assign stall = |(rd_req & rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_req;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_full;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flush;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        stall;
        logic        full;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    regfile_scoreboard dut (
        .Clk      (clk),
        .Reset    (reset_n),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_full (iss_full),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_field(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, want %h", tag, act, want);
    endtask

    // Drives one cycle's inputs just after the rising edge.
    task automatic apply_stimulus(input logic rst, input logic ie, input logic [4:0] ia,
                                  input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
                                  input logic [1:0] req);
        @(posedge clk);
        #1;
        reset_n  = rst;
        iss_en   = ie;
        iss_addr = ia;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        flush    = fl;
        rd_addr  = {ra1, ra0};
        rd_req   = req;
    endtask

    task automatic check_output(input string name, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] busy, input logic st, input logic full);
        exp_t e;
        e.name  = name;
        e.d0    = d0;
        e.d1    = d1;
        e.busy  = busy;
        e.stall = st;
        e.full  = full;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_field({e.name, " rd_data0"}, rd_data[31:0], e.d0);
                check_field({e.name, " rd_data1"}, rd_data[63:32], e.d1);
                check_field({e.name, " rd_busy"}, {30'd0, rd_busy}, {30'd0, e.busy});
                check_field({e.name, " stall"}, {31'd0, stall}, {31'd0, e.stall});
                check_field({e.name, " iss_full"}, {31'd0, iss_full}, {31'd0, e.full});
            end
        end
    end

    initial begin
        reset_n = 1'b0; iss_en = 1'b0; iss_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; flush = 1'b0; rd_addr = '0; rd_req = '0;

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 0, 2'b11);
        check_output("in_reset", 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 5, 0, 2'b11);
        check_output("after_reset", 0, 0, 2'b00, 0, 0);

        apply_stimulus(1, 1, 5, 0, 0, 0, 0, 5, 0, 2'b01);
        check_output("issue_r5", 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 0, 5, 0, 0, 0, 0, 5, 0, 2'b01);
        check_output("r5_stall", 0, 0, 2'b01, 1, 0);
        apply_stimulus(1, 0, 5, 1, 5, 32'hDEADBEEF, 0, 5, 0, 2'b01);
        check_output("wb_r5", BYP ? 32'hDEADBEEF : 32'h0, 0, BYP ? 2'b00 : 2'b01, !BYP, 0);
        apply_stimulus(1, 0, 5, 0, 0, 0, 0, 5, 0, 2'b01);
        check_output("r5_done", 32'hDEADBEEF, 0, 2'b00, 0, 0);

        apply_stimulus(1, 1, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_iss1", 0, 32'hDEADBEEF, 2'b00, 0, 0);
        apply_stimulus(1, 1, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_iss2", 0, 32'hDEADBEEF, 2'b01, 0, 0);
        apply_stimulus(1, 1, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_iss3", 0, 32'hDEADBEEF, 2'b01, 0, 0);
        apply_stimulus(1, 1, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_iss4_full", 0, 32'hDEADBEEF, 2'b01, 0, 1);
        apply_stimulus(1, 0, 7, 1, 7, 32'h77, 0, 7, 5, 2'b00);
        check_output("r7_wb1_dropped", BYP ? 32'h77 : 32'h0, 32'hDEADBEEF, 2'b01, 0, 1);
        apply_stimulus(1, 0, 7, 1, 7, 32'h77, 0, 7, 5, 2'b00);
        check_output("r7_wb2", 32'h77, 32'hDEADBEEF, 2'b01, 0, 0);
        apply_stimulus(1, 0, 7, 1, 7, 32'h77, 0, 7, 5, 2'b00);
        check_output("r7_wb3", 32'h77, 32'hDEADBEEF, BYP ? 2'b00 : 2'b01, 0, 0);
        apply_stimulus(1, 0, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_idle", 32'h77, 32'hDEADBEEF, 2'b00, 0, 0);
        apply_stimulus(1, 0, 7, 1, 7, 32'h78, 0, 7, 5, 2'b00);
        check_output("r7_wb_at_zero", BYP ? 32'h78 : 32'h77, 32'hDEADBEEF, 2'b00, 0, 0);
        apply_stimulus(1, 1, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_no_wrap", 32'h78, 32'hDEADBEEF, 2'b00, 0, 0);
        apply_stimulus(1, 0, 7, 0, 0, 0, 0, 7, 5, 2'b00);
        check_output("r7_count1", 32'h78, 32'hDEADBEEF, 2'b01, 0, 0);

        apply_stimulus(1, 1, 9, 0, 0, 0, 0, 9, 7, 2'b00);
        check_output("r9_iss", 0, 32'h78, 2'b10, 0, 0);
        apply_stimulus(1, 1, 9, 1, 9, 32'h99, 0, 9, 7, 2'b00);
        check_output("r9_iss_and_wb", BYP ? 32'h99 : 32'h0, 32'h78, 2'b11, 0, 0);
        apply_stimulus(1, 0, 9, 0, 0, 0, 0, 9, 7, 2'b00);
        check_output("r9_still1", 32'h99, 32'h78, 2'b11, 0, 0);

        apply_stimulus(1, 1, 3, 0, 0, 0, 0, 3, 9, 2'b01);
        check_output("r3_iss", 0, 32'h99, 2'b10, 0, 0);
        apply_stimulus(1, 0, 3, 1, 3, 32'h1234, 0, 3, 9, 2'b01);
        check_output("r3_bypass", BYP ? 32'h1234 : 32'h0, 32'h99, BYP ? 2'b10 : 2'b11, !BYP, 0);
        apply_stimulus(1, 0, 3, 0, 0, 0, 0, 3, 9, 2'b01);
        check_output("r3_done", 32'h1234, 32'h99, 2'b10, 0, 0);

        apply_stimulus(1, 1, 2, 0, 0, 0, 0, 2, 4, 2'b00);
        check_output("iss_r2", 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 1, 4, 0, 0, 0, 0, 2, 4, 2'b00);
        check_output("iss_r4", 0, 0, 2'b01, 0, 0);
        apply_stimulus(1, 1, 6, 0, 0, 0, 0, 2, 4, 2'b00);
        check_output("iss_r6", 0, 0, 2'b11, 0, 0);
        apply_stimulus(1, 1, 6, 1, 2, 32'h2222, 1, 2, 6, 2'b00);
        check_output("flush", BYP ? 32'h2222 : 32'h0, 0, BYP ? 2'b10 : 2'b11, 0, 0);
        apply_stimulus(1, 0, 6, 0, 0, 0, 0, 2, 6, 2'b00);
        check_output("post_flush_r2r6", 32'h2222, 0, 2'b00, 0, 0);
        apply_stimulus(1, 0, 6, 0, 0, 0, 0, 7, 9, 2'b11);
        check_output("post_flush_r7r9", 32'h78, 32'h99, 2'b00, 0, 0);
        apply_stimulus(1, 0, 6, 0, 0, 0, 0, 4, 3, 2'b11);
        check_output("post_flush_r4r3", 0, 32'h1234, 2'b00, 0, 0);

        apply_stimulus(1, 1, 5, 0, 0, 0, 0, 5, 3, 2'b11);
        check_output("pre_reset_iss", 32'hDEADBEEF, 32'h1234, 2'b00, 0, 0);
        apply_stimulus(1, 0, 5, 0, 0, 0, 0, 5, 3, 2'b01);
        check_output("pre_reset_busy", 32'hDEADBEEF, 32'h1234, 2'b01, 1, 0);
        apply_stimulus(0, 0, 5, 1, 5, 32'h5555, 0, 5, 3, 2'b11);
        check_output("mid_reset", 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 0, 5, 0, 0, 0, 0, 5, 3, 2'b11);
        check_output("after_mid_reset", 0, 0, 2'b00, 0, 0);

        apply_stimulus(1, 1, 0, 1, 0, 32'hFFFF, 0, 0, 0, 2'b11);
        check_output("r0_write", 0, 0, 2'b00, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        check_output("r0_reads_zero", 0, 0, 2'b00, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers; AW = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2: number of independent read ports.
REQ-004 Parameter CNT_MAX, default 3: maximum in-flight writes tracked per register.
REQ-005 Port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port Reset, input, 1: asynchronous, active-low reset.
REQ-007 Port rd_addr, input, NUM_RD*AW: packed read addresses, port i at [i*AW +: AW].
REQ-008 Port rd_req, input, NUM_RD: read port i is consumed by the instruction in decode.
REQ-009 Port rd_data, output, NUM_RD*DATA_W: packed read data.
REQ-010 Port rd_busy, output, NUM_RD: the addressed register has pending writes.
REQ-011 Port stall, output, 1: OR over i of (rd_req[i] AND rd_busy[i]).
REQ-012 Port iss_en / iss_addr, input, 1 / AW: issue marks iss_addr as a pending destination.
REQ-013 Port iss_full, output, 1: the iss_addr counter is at CNT_MAX.
REQ-014 Port wr_en / wr_addr / wr_data, input, 1 / AW / DATA_W: writeback port.
REQ-015 Port flush, input, 1: clears all pending counts.

Function
REQ-016 Reads shall be combinational; rd_data[i] = regs[rd_addr[i]].
REQ-017 Register 0 shall read as zero, ignore writes, and never become pending; rd_busy for address 0 shall be 0.
REQ-018 When wr_en=1 and wr_addr!=0, regs[wr_addr] shall update to wr_data on the rising edge.
REQ-019 Each register shall have a pending counter of width clog2(CNT_MAX+1).
REQ-020 An accepted issue (iss_en=1, iss_full=0, iss_addr!=0) shall increment the counter of iss_addr.
REQ-021 An issue while iss_full=1 shall be dropped, with the counter unchanged.
REQ-022 wr_en=1 shall decrement the counter of wr_addr; a decrement at 0 shall saturate at 0.
REQ-023 An accepted issue and a writeback to the same address in the same cycle shall leave the counter unchanged.
REQ-024 rd_busy[i] shall be 1 iff counter[rd_addr[i]] != 0 and no rd_busy override applies (REQ-034).
REQ-025 stall shall be combinational with zero latency.
REQ-026 flush=1 shall zero all counters on the next edge and take priority over a same-cycle issue or writeback to the counters.
REQ-027 The register data write shall still occur during flush.
REQ-028 Out-of-range addresses (>= NUM_REGS) shall read zero, ignore writes and issues, and report busy=0.

Reset
REQ-029 While Reset=0, all registers and all counters shall be 0 asynchronously.
REQ-030 While Reset=0, rd_data, rd_busy, stall and iss_full shall all read 0.
REQ-031 The first edge after Reset deasserts shall process inputs normally.
REQ-032 Reset asserted mid-operation shall discard pending state with no partial update.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN selects write-through bypass.
REQ-034 With REGFILE_BYPASS_EN defined: when wr_en=1 and wr_addr==rd_addr[i]!=0, rd_data[i]=wr_data in the same cycle. If that writeback takes the counter from 1 to 0, rd_busy[i]=0 in that cycle.
REQ-035 Without REGFILE_BYPASS_EN: reads return the stored value; new data is visible the cycle after the write; rd_busy follows the registered counter only.

Structure
REQ-036 Shared package regfile_pkg shall hold default DATA_W, NUM_REGS, NUM_RD and CNT_MAX, and the pending-count typedef.
REQ-037 Sub-module pend_counter (saturating up/down counter with inc, dec, clr, full and nonzero outputs) shall be instantiated once per register.

Verification
REQ-038 Reset low, then high; read ports at r5 and r0 -> rd_data=0, rd_busy=0, stall=0.
REQ-039 Issue r5; next cycle rd_addr0=5, rd_req0=1 -> stall=1. Write r5=0xDEADBEEF -> after the edge: stall=0 and rd_data0=0xDEADBEEF.
REQ-040 Issue r7 three times (CNT_MAX=3) -> iss_full=1; a fourth issue is dropped; three writebacks to r7 -> rd_busy=0.
REQ-041 Same cycle: issue r9 and writeback r9 with count 1 -> count stays 1, busy stays 1.
REQ-042 With REGFILE_BYPASS_EN: count r3=1, wr r3=0x1234 while reading r3 -> rd_data=0x1234, rd_busy=0, stall=0 in that cycle. Without the macro -> old data and busy=1 in that cycle.
REQ-043 Pending on r2, r4 and r6, assert flush -> all rd_busy=0 next cycle. Reset pulsed low mid-sequence -> all state 0 immediately.
